// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_pkg
// Description : Shared types and constants for the multiplexed-address DRAM
//               bank model: controller states, access-latency limits and the
//               refresh counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_pkg;

  // Bank controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROW   = 3'd1,
    CBR   = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dram_state_e;

  // Legal range of the CAS-to-data latency, in OSC cycles
  localparam int ACCESS_DELAY_MIN = 1;
  localparam int ACCESS_DELAY_MAX = 7;

  // Width of the latency counter; holds ACCESS_DELAY_MAX
  localparam int LAT_W = 3;

  // Width of the refresh event counter
  localparam int REFRESH_CNT_W = 16;

  // Force an out-of-range latency parameter into the legal window
  function automatic logic [LAT_W-1:0] clamp_delay(input int delay);
    if (delay < ACCESS_DELAY_MIN) begin
      return LAT_W'(ACCESS_DELAY_MIN);
    end else if (delay > ACCESS_DELAY_MAX) begin
      return LAT_W'(ACCESS_DELAY_MAX);
    end else begin
      return LAT_W'(delay);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/dram_strobe_edge.sv
`default_nettype none
// ============================================================================
// Module      : dram_strobe_edge
// Description : Registers the active-low DRAM strobes and reports their
//               sampled falling/rising edges. Reset loads the history with
//               the live strobe levels, so a strobe held low across reset
//               release is not seen as an edge.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_n_ras,
  input  logic i_n_cas,
  input  logic i_n_we,
  output logic o_ras_fall,
  output logic o_ras_rise,
  output logic o_cas_fall,
  output logic o_cas_rise,
  output logic o_we_fall
);

  // Bit order: {n_RAS, n_CAS, n_WE}
  logic [2:0] now_lvl;
  logic [2:0] prev_q;
  logic [2:0] prev_d;

  assign now_lvl = {i_n_ras, i_n_cas, i_n_we};

  // History always follows the live level; reset takes the same value
  always_comb begin
    prev_d = now_lvl;
  end

  // Strobe history register, loaded with the current levels during reset
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= now_lvl;
    end else begin
      prev_q <= prev_d;
    end
  end

  // No edges are reported while reset is held
  assign o_ras_fall = ~rst &  prev_q[2] & ~now_lvl[2];
  assign o_ras_rise = ~rst & ~prev_q[2] &  now_lvl[2];
  assign o_cas_fall = ~rst &  prev_q[1] & ~now_lvl[1];
  assign o_cas_rise = ~rst & ~prev_q[1] &  now_lvl[1];
  assign o_we_fall  = ~rst &  prev_q[0] & ~now_lvl[0];

endmodule
`default_nettype wire

// File: rtl/dram_mux_model.sv
`default_nettype none
// ============================================================================
// Module      : dram_mux_model
// Description : Cycle-sampled model of a multiplexed-address page-mode DRAM
//               bank. Supports early write, delayed read, read-modify-write,
//               page mode, RAS-only and CAS-before-RAS refresh, and flags
//               protocol violations on ERR.
//               Optional build macro DRAM_DECAY_EN adds per-row retention
//               ageing; without it data is retained indefinitely.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_mux_model
  import dram_pkg::*;
#(
  parameter int ADDR_BITS        = 7,
  parameter int DATA_BITS        = 8,
  parameter int ACCESS_DELAY     = 2,
  parameter int RETENTION_CYCLES = 65536
) (
  input  logic                     OSC,
  input  logic                     RESET,
  input  logic [ADDR_BITS-1:0]     A,
  input  logic [DATA_BITS-1:0]     Din,
  input  logic                     n_RAS,
  input  logic                     n_CAS,
  input  logic                     n_WE,
  output logic [DATA_BITS-1:0]     Dout,
  output logic                     Dout_oe,
  output logic                     ERR,
  output logic [REFRESH_CNT_W-1:0] REFRESH_CNT
);

  localparam int WORDS = 1 << (2 * ADDR_BITS);
  localparam logic [LAT_W-1:0] LAT_LOAD = clamp_delay(ACCESS_DELAY);

  logic ras_fall, ras_rise, cas_fall, cas_rise, we_fall;

  dram_strobe_edge u_edge (
    .clk        (OSC),
    .rst        (RESET),
    .i_n_ras    (n_RAS),
    .i_n_cas    (n_CAS),
    .i_n_we     (n_WE),
    .o_ras_fall (ras_fall),
    .o_ras_rise (ras_rise),
    .o_cas_fall (cas_fall),
    .o_cas_rise (cas_rise),
    .o_we_fall  (we_fall)
  );

  logic [DATA_BITS-1:0] mem [WORDS];

  dram_state_e              state_q, state_d;
  logic [ADDR_BITS-1:0]     row_q, row_d;
  logic [ADDR_BITS-1:0]     col_q, col_d;
  logic [LAT_W-1:0]         lat_q, lat_d;
  logic [DATA_BITS-1:0]     dout_q, dout_d;
  logic                     oe_q, oe_d;
  logic                     err_q, err_d;
  logic [REFRESH_CNT_W-1:0] rcnt_q, rcnt_d;
  logic                     cas_seen_q, cas_seen_d;

  logic                     mem_we;
  logic [2*ADDR_BITS-1:0]   mem_waddr;
  logic [DATA_BITS-1:0]     mem_rdata;
  logic                     row_stale;

  assign mem_rdata = mem[{row_q, col_q}];

  // Next-state, memory-write and output decode for the bank controller
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    lat_d      = lat_q;
    dout_d     = dout_q;
    oe_d       = oe_q;
    err_d      = 1'b0;
    rcnt_d     = rcnt_q;
    cas_seen_d = cas_seen_q;
    mem_we     = 1'b0;
    mem_waddr  = {row_q, col_q};

    case (state_q)
      IDLE: begin
        if (ras_fall) begin
          if (!n_CAS) begin
            // CAS already low (or falling together): CAS-before-RAS refresh
            state_d = CBR;
            rcnt_d  = rcnt_q + 1'b1;
            err_d   = cas_fall;
          end else begin
            state_d    = ROW;
            row_d      = A;
            cas_seen_d = 1'b0;
          end
        end
      end

      CBR: begin
        if (ras_rise) begin
          state_d = IDLE;
        end
      end

      ROW, READ, WRITE: begin
        if (ras_rise) begin
          // RAS rise closes the page from any open state and wins over CAS
          state_d = IDLE;
          oe_d    = 1'b0;
          lat_d   = '0;
          err_d   = ~n_CAS;
          if ((state_q == ROW) && !cas_seen_q) begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end else if (state_q == ROW) begin
          if (cas_fall) begin
            col_d      = A;
            cas_seen_d = 1'b1;
            if (!n_WE) begin
              state_d   = WRITE;
              mem_we    = 1'b1;
              mem_waddr = {row_q, A};
            end else begin
              state_d = READ;
              lat_d   = LAT_LOAD;
            end
          end
        end else if (state_q == READ) begin
          if (cas_rise) begin
            // CAS released before data was presented: aborted access
            state_d = ROW;
            oe_d    = 1'b0;
            lat_d   = '0;
            err_d   = ~oe_q;
          end else begin
            if (lat_q != '0) begin
              lat_d = lat_q - 1'b1;
              if (lat_q == LAT_W'(1)) begin
                oe_d = 1'b1;
                if (row_stale) begin
                  dout_d = '1;
                  err_d  = 1'b1;
                end else begin
                  dout_d = mem_rdata;
                end
              end
            end
            if (we_fall) begin
              mem_we = 1'b1;
            end
          end
        end else begin
          if (cas_rise) begin
            state_d = ROW;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller and output registers; memory contents survive reset
  always_ff @(posedge OSC) begin
    if (RESET) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      lat_q      <= '0;
      dout_q     <= '0;
      oe_q       <= 1'b0;
      err_q      <= 1'b0;
      rcnt_q     <= '0;
      cas_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      lat_q      <= lat_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      err_q      <= err_d;
      rcnt_q     <= rcnt_d;
      cas_seen_q <= cas_seen_d;
    end
  end

  // Storage array write port
  always_ff @(posedge OSC) begin
    if (mem_we && !RESET) begin
      mem[mem_waddr] <= Din;
    end
  end

`ifdef DRAM_DECAY_EN
  localparam int ROWS  = 1 << ADDR_BITS;
  localparam int AGE_W = $clog2(RETENTION_CYCLES + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(RETENTION_CYCLES);

  logic                 row_open;
  logic                 cbr_start;
  logic [ROWS-1:0]      age_sat;
  logic [ADDR_BITS-1:0] rfsh_ptr_q, rfsh_ptr_d;
  logic                 stale_q, stale_d;

  assign row_open  = (state_q == IDLE) && ras_fall &&  n_CAS;
  assign cbr_start = (state_q == IDLE) && ras_fall && !n_CAS;

  for (genvar r = 0; r < ROWS; r++) begin : g_age
    logic [AGE_W-1:0] age_q, age_d;

    // Row age: cleared when the row is opened or CBR-refreshed, else saturates
    always_comb begin
      age_d = age_q;
      if ((row_open && (A == ADDR_BITS'(r))) ||
          (cbr_start && (rfsh_ptr_q == ADDR_BITS'(r)))) begin
        age_d = '0;
      end else if (age_q != AGE_MAX) begin
        age_d = age_q + 1'b1;
      end
    end

    // Row age register
    always_ff @(posedge OSC) begin
      if (RESET) begin
        age_q <= '0;
      end else begin
        age_q <= age_d;
      end
    end

    assign age_sat[r] = (age_q == AGE_MAX);
  end

  // A row found expired when opened reads back as lost until a write in the
  // same page re-establishes it; CBR walks the refresh pointer
  always_comb begin
    stale_d    = stale_q;
    rfsh_ptr_d = rfsh_ptr_q;
    if (row_open) begin
      stale_d = age_sat[A];
    end else if (mem_we) begin
      stale_d = 1'b0;
    end
    if (cbr_start) begin
      rfsh_ptr_d = rfsh_ptr_q + 1'b1;
    end
  end

  // Retention bookkeeping registers
  always_ff @(posedge OSC) begin
    if (RESET) begin
      stale_q    <= 1'b0;
      rfsh_ptr_q <= '0;
    end else begin
      stale_q    <= stale_d;
      rfsh_ptr_q <= rfsh_ptr_d;
    end
  end

  assign row_stale = stale_q;
`else
  assign row_stale = 1'b0;
`endif

  assign Dout        = dout_q;
  assign Dout_oe     = oe_q;
  assign ERR         = err_q;
  assign REFRESH_CNT = rcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_mux_model.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dram_mux_model
// Description : Directed self-checking bench for dram_mux_model. Inputs
//               change 1 ns after a rising OSC edge and outputs are examined
//               at the same point, so each step observes one sampled edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_mux_model;

  localparam int ADDR_BITS    = 7;
  localparam int DATA_BITS    = 8;
  localparam int ACCESS_DELAY = 2;
`ifdef DRAM_DECAY_EN
  localparam int RETENTION_CYCLES = 100;
`else
  localparam int RETENTION_CYCLES = 65536;
`endif

  logic                 OSC = 1'b0;
  logic                 RESET;
  logic [ADDR_BITS-1:0] A;
  logic [DATA_BITS-1:0] Din;
  logic                 n_RAS, n_CAS, n_WE;
  logic [DATA_BITS-1:0] Dout;
  logic                 Dout_oe, ERR;
  logic [15:0]          REFRESH_CNT;

  int tests_run    = 0;
  int tests_failed = 0;
  int err_pulses   = 0;

  dram_mux_model #(
    .ADDR_BITS        (ADDR_BITS),
    .DATA_BITS        (DATA_BITS),
    .ACCESS_DELAY     (ACCESS_DELAY),
    .RETENTION_CYCLES (RETENTION_CYCLES)
  ) dut (
    .OSC         (OSC),
    .RESET       (RESET),
    .A           (A),
    .Din         (Din),
    .n_RAS       (n_RAS),
    .n_CAS       (n_CAS),
    .n_WE        (n_WE),
    .Dout        (Dout),
    .Dout_oe     (Dout_oe),
    .ERR         (ERR),
    .REFRESH_CNT (REFRESH_CNT)
  );

  always #5 OSC = ~OSC;

  // Count every cycle in which ERR is high
  always @(negedge OSC) begin
    if (ERR === 1'b1) err_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge OSC);
    #1;
  endtask

  task automatic apply_reset();
    RESET = 1'b1; n_RAS = 1'b1; n_CAS = 1'b1; n_WE = 1'b1;
    step(); step();
    RESET = 1'b0;
    step();
  endtask

  task automatic ras_open(input logic [ADDR_BITS-1:0] row);
    A = row; n_RAS = 1'b0;
    step();
  endtask

  task automatic ras_close();
    n_RAS = 1'b1;
    step();
  endtask

  task automatic write_col(input logic [ADDR_BITS-1:0] col, input logic [DATA_BITS-1:0] d);
    A = col; Din = d; n_WE = 1'b0; n_CAS = 1'b0;
    step();
    n_CAS = 1'b1; n_WE = 1'b1;
    step();
  endtask

  // Read one column; lat = cycles from the sampled CAS fall to Dout_oe (99 = never)
  task automatic read_col(input logic [ADDR_BITS-1:0] col,
                          output logic [DATA_BITS-1:0] d, output int lat);
    A = col; n_WE = 1'b1; n_CAS = 1'b0;
    step();
    lat = 99;
    d   = 'x;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (Dout_oe === 1'b1) begin
        lat = i;
        d   = Dout;
        break;
      end
    end
    n_CAS = 1'b1;
    step();
  endtask

  task automatic test_reset();
    RESET = 1'b1; A = '0; Din = '0; n_RAS = 1'b1; n_CAS = 1'b1; n_WE = 1'b1;
    step(); step();
    tests_run++;
    if (Dout !== 8'h00) begin tests_failed++; $display("FAIL reset_dout: got %h expected 00", Dout); end
    tests_run++;
    if (Dout_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_oe: got %b expected 0", Dout_oe); end
    tests_run++;
    if (ERR !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", ERR); end
    tests_run++;
    if (REFRESH_CNT !== 16'd0) begin tests_failed++; $display("FAIL reset_rcnt: got %0d expected 0", REFRESH_CNT); end
    RESET = 1'b0;
    step();
  endtask

  task automatic test_early_write_read();
    logic [DATA_BITS-1:0] d;
    int lat;
    int e0;
    e0 = err_pulses;
    ras_open(7'h05); write_col(7'h21, 8'hA5); ras_close();
    ras_open(7'h05); read_col(7'h21, d, lat); ras_close();
    step();
    tests_run++;
    if (d !== 8'hA5) begin tests_failed++; $display("FAIL ewr_data: got %h expected a5", d); end
    tests_run++;
    if (lat != 2) begin tests_failed++; $display("FAIL ewr_latency: got %0d expected 2", lat); end
    tests_run++;
    if (err_pulses != e0) begin tests_failed++; $display("FAIL ewr_err: got %0d pulses expected 0", err_pulses - e0); end
  endtask

  task automatic test_page_mode();
    logic [DATA_BITS-1:0] exp_d [4];
    logic [DATA_BITS-1:0] d;
    int lat;
    int e0;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    e0 = err_pulses;
    ras_open(7'h10);
    for (int c = 0; c < 4; c++) write_col(ADDR_BITS'(c), exp_d[c]);
    for (int c = 0; c < 4; c++) begin
      read_col(ADDR_BITS'(c), d, lat);
      tests_run++;
      if (d !== exp_d[c] || lat != 2) begin
        tests_failed++;
        $display("FAIL page_read col%0d: got %h lat %0d expected %h lat 2", c, d, lat, exp_d[c]);
      end
    end
    ras_close();
    step();
    tests_run++;
    if (err_pulses != e0) begin tests_failed++; $display("FAIL page_err: got %0d pulses expected 0", err_pulses - e0); end
  endtask

  task automatic test_rmw();
    logic [DATA_BITS-1:0] d;
    int lat;
    ras_open(7'h05); write_col(7'h21, 8'hA5); ras_close();
    ras_open(7'h05);
    A = 7'h21; n_WE = 1'b1; n_CAS = 1'b0;
    step(); step(); step();
    tests_run++;
    if (Dout_oe !== 1'b1 || Dout !== 8'hA5) begin
      tests_failed++; $display("FAIL rmw_read: got oe %b data %h expected oe 1 data a5", Dout_oe, Dout);
    end
    Din = 8'h5A; n_WE = 1'b0;
    step();
    tests_run++;
    if (Dout_oe !== 1'b1 || Dout !== 8'hA5) begin
      tests_failed++; $display("FAIL rmw_hold: got oe %b data %h expected oe 1 data a5", Dout_oe, Dout);
    end
    n_CAS = 1'b1; n_WE = 1'b1;
    step();
    tests_run++;
    if (Dout_oe !== 1'b0) begin tests_failed++; $display("FAIL rmw_oe_drop: got %b expected 0", Dout_oe); end
    read_col(7'h21, d, lat);
    ras_close();
    tests_run++;
    if (d !== 8'h5A) begin tests_failed++; $display("FAIL rmw_readback: got %h expected 5a", d); end
  endtask

  task automatic test_refresh();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      n_CAS = 1'b0; step();
      n_RAS = 1'b0; step();
      n_RAS = 1'b1; step();
      n_CAS = 1'b1; step();
    end
    for (int i = 0; i < 2; i++) begin
      ras_open(7'h33); ras_close();
    end
    tests_run++;
    if (REFRESH_CNT !== 16'd5) begin tests_failed++; $display("FAIL refresh_count: got %0d expected 5", REFRESH_CNT); end
    n_RAS = 1'b0; n_CAS = 1'b0;
    step();
    tests_run++;
    if (REFRESH_CNT !== 16'd6) begin tests_failed++; $display("FAIL refresh_simul_count: got %0d expected 6", REFRESH_CNT); end
    tests_run++;
    if (ERR !== 1'b1) begin tests_failed++; $display("FAIL refresh_simul_err: got %b expected 1", ERR); end
    step();
    tests_run++;
    if (ERR !== 1'b0) begin tests_failed++; $display("FAIL refresh_err_width: got %b expected 0", ERR); end
    n_RAS = 1'b1; step();
    n_CAS = 1'b1; step();
  endtask

  task automatic test_abort();
    logic oe_seen;
    int e0;
    e0 = err_pulses;
    ras_open(7'h05);
    A = 7'h21; n_WE = 1'b1; n_CAS = 1'b0;
    step();
    n_CAS = 1'b1;
    step();
    tests_run++;
    if (ERR !== 1'b1) begin tests_failed++; $display("FAIL abort_err: got %b expected 1", ERR); end
    oe_seen = Dout_oe;
    for (int i = 0; i < 4; i++) begin step(); oe_seen |= Dout_oe; end
    tests_run++;
    if (oe_seen !== 1'b0) begin tests_failed++; $display("FAIL abort_oe: got %b expected 0", oe_seen); end
    ras_close();
    step();
    tests_run++;
    if (err_pulses - e0 != 1) begin tests_failed++; $display("FAIL abort_err_count: got %0d expected 1", err_pulses - e0); end
  endtask

  task automatic test_reset_mid_read();
    logic [DATA_BITS-1:0] d;
    logic oe_seen;
    int lat;
    int e0;
    ras_open(7'h05);
    A = 7'h21; n_WE = 1'b1; n_CAS = 1'b0;
    step(); step();
    RESET = 1'b1;
    step();
    e0 = err_pulses;
    tests_run++;
    if (Dout !== 8'h00 || Dout_oe !== 1'b0 || ERR !== 1'b0 || REFRESH_CNT !== 16'd0) begin
      tests_failed++;
      $display("FAIL midread_reset: got dout %h oe %b err %b rcnt %0d expected 00 0 0 0", Dout, Dout_oe, ERR, REFRESH_CNT);
    end
    RESET = 1'b0;
    oe_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin step(); oe_seen |= Dout_oe; end
    tests_run++;
    if (oe_seen !== 1'b0) begin tests_failed++; $display("FAIL midread_no_access: got oe %b expected 0", oe_seen); end
    n_CAS = 1'b1; step();
    n_RAS = 1'b1; step();
    tests_run++;
    if (REFRESH_CNT !== 16'd0) begin tests_failed++; $display("FAIL midread_rcnt: got %0d expected 0", REFRESH_CNT); end
    ras_open(7'h05); read_col(7'h21, d, lat); ras_close();
    step();
    tests_run++;
    if (d !== 8'h5A || lat != 2) begin tests_failed++; $display("FAIL midread_reaccess: got %h lat %0d expected 5a lat 2", d, lat); end
    tests_run++;
    if (err_pulses != e0) begin tests_failed++; $display("FAIL midread_err: got %0d pulses expected 0", err_pulses - e0); end
  endtask

`ifdef DRAM_DECAY_EN
  task automatic test_decay();
    logic [DATA_BITS-1:0] d;
    int lat;
    int e0;
    ras_open(7'h02); write_col(7'h07, 8'h3C); ras_close();
    repeat (120) step();
    e0 = err_pulses;
    ras_open(7'h02); read_col(7'h07, d, lat); ras_close();
    step();
    tests_run++;
    if (d !== 8'hFF) begin tests_failed++; $display("FAIL decay_lost: got %h expected ff", d); end
    tests_run++;
    if (err_pulses - e0 != 1) begin tests_failed++; $display("FAIL decay_err: got %0d pulses expected 1", err_pulses - e0); end
    ras_open(7'h02); write_col(7'h07, 8'h3C); ras_close();
    repeat (50) step();
    ras_open(7'h02); ras_close();
    repeat (70) step();
    ras_open(7'h02); read_col(7'h07, d, lat); ras_close();
    tests_run++;
    if (d !== 8'h3C) begin tests_failed++; $display("FAIL decay_refreshed: got %h expected 3c", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_early_write_read();
    test_page_mode();
    test_rmw();
    test_refresh();
    test_abort();
    test_reset_mid_read();
`ifdef DRAM_DECAY_EN
    test_decay();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
